hdmi_rx_timing_meter: RTL
=========================

// Module: hdmi_rx_timing_meter
// PURPOSE
//  Sits directly downstream of the ADV HDMI parallel pins (hdmi_data/hs/vs/de) and samples them on the
//  pixel clock. Measures active/total line and frame timing, declares a stable-timing lock, and
//  re-emits a registered pixel stream with start-of-frame and end-of-line markers.
//  Feeds the frame-buffer writer and the UART status reporter.
// PARAMETERS
//  CNT_W        12         width of all timing counters/outputs; counters saturate at all-ones
//  HS_POL       1          active level of hdmi_hs (1 = active-high)
//  VS_POL       1          active level of hdmi_vs
//  LOCK_FRAMES  3          consecutive identical frame measurements needed for lock (1..15)
//  TIMEOUT_CYC  4000000    clocks without a VS leading edge before measurement is dropped (< 2^23)
// PORTS
//  clk_in       in   1      pixel clock; all logic on rising edge
//  rst_n_in     in   1      synchronous, active-low reset
//  hdmi_data    in   24     RGB pixel
//  hdmi_hs      in   1      horizontal sync, level per HS_POL
//  hdmi_vs      in   1      vertical sync, level per VS_POL
//  hdmi_de      in   1      data enable
//  pix_data     out  24     registered pixel
//  pix_valid    out  1      pix_data holds an active pixel
//  pix_sof      out  1      first valid pixel of a frame
//  pix_eol      out  1      last valid pixel of a line
//  meas_h_act   out  CNT_W  DE-high clocks of last DE line of the measured frame
//  meas_h_tot   out  CNT_W  clocks between the last two HS leading edges of the measured frame
//  meas_v_act   out  CNT_W  DE lines in measured frame
//  meas_v_tot   out  CNT_W  HS leading edges in measured frame
//  meas_valid   out  1      meas_* hold a complete frame measurement
//  locked       out  1      timing stable for LOCK_FRAMES consecutive comparisons
//  frame_cnt    out  16     count of VS leading edges, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: every output 0; internal counters, pipeline, frame_seen, stable_cnt, watchdog cleared.
//  - Pipeline: pins -> s1 reg -> s2 reg -> output reg; pix_* appear exactly 3 clocks after pins.
//  - Edges from s1 vs s2: HS/VS leading edge = transition to the active level; DE rise/fall likewise.
//  - pix_valid=s2.de; pix_eol=s2.de & ~s1.de; pix_sof=s2.de & sof_pend. sof_pend is set on VS leading
//    edge and cleared when pix_sof fires. A DE line of width 1 gives sof and eol on the same pixel.
//  - Line: h_cnt runs every clock, restarts at 1 on HS edge; h_tot_r<=h_cnt at HS edge.
//    de_cnt counts DE-high clocks; on DE fall, h_act_r<=de_cnt and de_cnt<=0.
//  - Frame: v_tot_r counts HS edges and v_act_r counts DE rises. At VS edge both restart
//    (an HS edge on the same clock counts as 1); h_act_r cleared.
//  - At each VS leading edge: frame_cnt++. If frame_seen=0: frame_seen<=1, no update.
//    Else meas_*<=current frame values, meas_valid<=1.
//    If meas_valid was already 1 and all four new values equal the old meas_*: stable_cnt++ (saturate).
//    Otherwise stable_cnt<=0.
//  - locked = (stable_cnt==LOCK_FRAMES), registered; drops in the same clock a mismatch is latched.
//  - Watchdog: clears on VS edge, else increments. On reaching TIMEOUT_CYC: meas_valid, locked,
//    stable_cnt, frame_seen <= 0; meas_* keep last values. The watchdog then holds until next VS edge.
//  - Saturation: any counter at all-ones holds; a saturated value is still compared/latched as-is.
//  - Simultaneous HS+VS edge: line closes first, then frame closes; DE fall on VS edge updates h_act_r
//    before the frame latch (value included in measured frame).
//  - Reset mid-frame: all state cleared; first post-reset VS edge only arms frame_seen.
// TESTING
//  1 Hold rst_n_in=0 with toggling pins -> all outputs 0 for every cycle of reset and 1 cycle after.
//  2 Frame h_tot=20,h_act=12,v_tot=10,v_act=6, LOCK_FRAMES=2 -> VS edge#2 meas=12/20/6/10,meas_valid=1;
//    locked=1 after VS edge#4.
//  3 From locked, change h_act to 11 for one frame -> locked=0 at next VS edge, meas_h_act=11;
//    relocks 2 frames later.
//  4 Stop VS for TIMEOUT_CYC (set 1000) -> meas_valid=locked=0 at clock 1000;
//    restart -> first VS edge only arms.
//  5 Ramp pixel data 0..11 per line -> pix_data equals pin data 3 clocks later; pix_eol on value 11;
//    pix_sof only on first pixel after VS.
//  6 Assert rst_n_in mid-line, release -> outputs 0, frame_cnt=0, no stale sof/eol, measurement restarts.

Source files
------------

// File: rtl/hdmi_rx_timing_meter.sv
// HDMI receive timing meter: registers the parallel video pins, re-emits the pixel stream with
// start-of-frame / end-of-line markers, measures line and frame timing and declares lock once
// the measurement has been stable for LOCK_FRAMES consecutive frames.
module hdmi_rx_timing_meter #(
  parameter int unsigned CNT_W       = 12,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned TIMEOUT_CYC = 4000000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [23:0]      hdmi_data,
  input  logic             hdmi_hs,
  input  logic             hdmi_vs,
  input  logic             hdmi_de,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic [CNT_W-1:0] meas_h_act,
  output logic [CNT_W-1:0] meas_h_tot,
  output logic [CNT_W-1:0] meas_v_act,
  output logic [CNT_W-1:0] meas_v_tot,
  output logic             meas_valid,
  output logic             locked,
  output logic [15:0]      frame_cnt
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t        CntOne  = cnt_t'(1);
  localparam logic [3:0]  LockN   = 4'(LOCK_FRAMES);
  localparam logic [23:0] WdLimit = 24'(TIMEOUT_CYC);

  // Saturating increment: all-ones holds.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + CntOne;
  endfunction

  // Input pipeline stages (s1 is the newer sample)
  logic [23:0] s1_data_q, s2_data_q;
  logic        s1_hs_q, s1_vs_q, s1_de_q;
  logic        s2_hs_q, s2_vs_q, s2_de_q;

  // Timing state
  cnt_t        h_cnt_q, h_tot_q, de_cnt_q, h_act_q, v_tot_q, v_act_q;
  cnt_t        h_cnt_d, h_tot_d, de_cnt_d, h_act_d, v_tot_d, v_act_d;
  cnt_t        line_h_act;
  cnt_t        meas_h_act_d, meas_h_tot_d, meas_v_act_d, meas_v_tot_d;
  logic        sof_pend_q, sof_pend_d;
  logic        frame_seen_q, frame_seen_d;
  logic [3:0]  stable_q, stable_d;
  logic [23:0] wd_q, wd_d;
  logic [15:0] frame_cnt_d;
  logic        meas_valid_d, locked_d;
  logic        hs_edge, vs_edge, de_rise, de_fall, timeout, same_meas;

  assign hs_edge = (s1_hs_q == HS_POL) && (s2_hs_q != HS_POL);
  assign vs_edge = (s1_vs_q == VS_POL) && (s2_vs_q != VS_POL);
  assign de_rise = s1_de_q & ~s2_de_q;
  assign de_fall = s2_de_q & ~s1_de_q;
  // Fires only on the clock the watchdog reaches its limit; afterwards it parks there.
  assign timeout = (wd_q != WdLimit) && ((wd_q + 24'd1) == WdLimit);

  // Next-state for line/frame counters, measurement latch, lock and watchdog
  always_comb begin
    h_cnt_d      = hs_edge ? CntOne : sat_inc(h_cnt_q);
    h_tot_d      = hs_edge ? h_cnt_q : h_tot_q;
    de_cnt_d     = de_fall ? '0 : (s1_de_q ? sat_inc(de_cnt_q) : de_cnt_q);
    // Line closes before the frame: a DE fall on the VS clock is part of the measured frame.
    line_h_act   = de_fall ? de_cnt_q : h_act_q;
    h_act_d      = line_h_act;
    v_tot_d      = hs_edge ? sat_inc(v_tot_q) : v_tot_q;
    v_act_d      = de_rise ? sat_inc(v_act_q) : v_act_q;
    sof_pend_d   = vs_edge | (sof_pend_q & ~s2_de_q);
    frame_cnt_d  = frame_cnt;
    frame_seen_d = frame_seen_q;
    meas_h_act_d = meas_h_act;
    meas_h_tot_d = meas_h_tot;
    meas_v_act_d = meas_v_act;
    meas_v_tot_d = meas_v_tot;
    meas_valid_d = meas_valid;
    stable_d     = stable_q;
    wd_d         = (wd_q == WdLimit) ? wd_q : wd_q + 24'd1;
    same_meas    = (line_h_act == meas_h_act) && (h_tot_d == meas_h_tot) &&
                   (v_act_q == meas_v_act) && (v_tot_q == meas_v_tot);

    if (vs_edge) begin
      h_act_d     = '0;
      v_tot_d     = hs_edge ? CntOne : '0;
      v_act_d     = de_rise ? CntOne : '0;
      frame_cnt_d = frame_cnt + 16'd1;
      wd_d        = '0;
      if (!frame_seen_q) begin
        frame_seen_d = 1'b1;
      end else begin
        meas_h_act_d = line_h_act;
        meas_h_tot_d = h_tot_d;
        meas_v_act_d = v_act_q;
        meas_v_tot_d = v_tot_q;
        meas_valid_d = 1'b1;
        if (meas_valid && same_meas) begin
          stable_d = (stable_q >= LockN) ? stable_q : stable_q + 4'd1;
        end else begin
          stable_d = '0;
        end
      end
    end else if (timeout) begin
      meas_valid_d = 1'b0;
      stable_d     = '0;
      frame_seen_d = 1'b0;
    end

    locked_d = (stable_d == LockN);
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_data_q    <= '0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      s1_de_q      <= 1'b0;
      s2_data_q    <= '0;
      s2_hs_q      <= 1'b0;
      s2_vs_q      <= 1'b0;
      s2_de_q      <= 1'b0;
      pix_data     <= '0;
      pix_valid    <= 1'b0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      h_cnt_q      <= '0;
      h_tot_q      <= '0;
      de_cnt_q     <= '0;
      h_act_q      <= '0;
      v_tot_q      <= '0;
      v_act_q      <= '0;
      sof_pend_q   <= 1'b0;
      frame_seen_q <= 1'b0;
      stable_q     <= '0;
      wd_q         <= '0;
      frame_cnt    <= '0;
      meas_h_act   <= '0;
      meas_h_tot   <= '0;
      meas_v_act   <= '0;
      meas_v_tot   <= '0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      s1_data_q    <= hdmi_data;
      s1_hs_q      <= hdmi_hs;
      s1_vs_q      <= hdmi_vs;
      s1_de_q      <= hdmi_de;
      s2_data_q    <= s1_data_q;
      s2_hs_q      <= s1_hs_q;
      s2_vs_q      <= s1_vs_q;
      s2_de_q      <= s1_de_q;
      pix_data     <= s2_data_q;
      pix_valid    <= s2_de_q;
      pix_sof      <= s2_de_q & sof_pend_q;
      pix_eol      <= s2_de_q & ~s1_de_q;
      h_cnt_q      <= h_cnt_d;
      h_tot_q      <= h_tot_d;
      de_cnt_q     <= de_cnt_d;
      h_act_q      <= h_act_d;
      v_tot_q      <= v_tot_d;
      v_act_q      <= v_act_d;
      sof_pend_q   <= sof_pend_d;
      frame_seen_q <= frame_seen_d;
      stable_q     <= stable_d;
      wd_q         <= wd_d;
      frame_cnt    <= frame_cnt_d;
      meas_h_act   <= meas_h_act_d;
      meas_h_tot   <= meas_h_tot_d;
      meas_v_act   <= meas_v_act_d;
      meas_v_tot   <= meas_v_tot_d;
      meas_valid   <= meas_valid_d;
      locked       <= locked_d;
    end
  end

endmodule
